// File: rtl/time_source_controller_pkg.sv
// Shared definitions for the clock-register write sequencer: time/date layout,
// FSM state encoding and the BCD minute increment used by the frame checker.
package time_source_controller_pkg;

    localparam int TD_W     = 44;
    // Everything from the hour field upwards must match between successive frames.
    localparam int DATE_LSB = 14;

    // 44-bit BCD time/date word, MSB first (TZ [43:42] .. SEC_LO [3:0]).
    typedef struct packed {
        logic [1:0] tz;
        logic [3:0] year_hi;
        logic [3:0] year_lo;
        logic       mon_hi;
        logic [3:0] mon_lo;
        logic [2:0] dow;
        logic [1:0] day_hi;
        logic [3:0] day_lo;
        logic [1:0] hour_hi;
        logic [3:0] hour_lo;
        logic [2:0] min_hi;
        logic [3:0] min_lo;
        logic [2:0] sec_hi;
        logic [3:0] sec_lo;
    } td_t;

    localparam logic [2:0] ST_FREE     = 3'd0;
    localparam logic [2:0] ST_CONFIRM  = 3'd1;
    localparam logic [2:0] ST_DCF_LOAD = 3'd2;
    localparam logic [2:0] ST_LOCKED   = 3'd3;
    localparam logic [2:0] ST_MANUAL   = 3'd4;
    localparam logic [2:0] ST_MAN_LOAD = 3'd5;

    // BCD minute + 1 for 00..58; the caller rejects 59 separately.
    function automatic logic [6:0] bcd_min_inc(input logic [6:0] m);
        if (m[3:0] == 4'd9) begin
            return {m[6:4] + 3'd1, 4'd0};
        end
        return {m[6:4], m[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/time_source_controller_dcf_frame_checker.sv
// Remembers the last DCF frame and flags whether the current frame is exactly
// one minute later within the same hour/day (seconds ignored).
module time_source_controller_dcf_frame_checker
    import time_source_controller_pkg::*;
(
    input  logic            clk,
    input  logic            nReset,
    input  logic [TD_W-1:0] frame,
    input  logic            capture,
    output logic            plausible
);

    logic [TD_W-1:0] prev_reg;
    td_t             prev_td;
    td_t             new_td;
    logic [6:0]      prev_min;
    logic [6:0]      new_min;

    assign prev_td  = prev_reg;
    assign new_td   = frame;
    assign prev_min = {prev_td.min_hi, prev_td.min_lo};
    assign new_min  = {new_td.min_hi, new_td.min_lo};

    // Minute 59 rolls the hour, so it can never pass the same-upper-fields test.
    assign plausible = (frame[TD_W-1:DATE_LSB] == prev_reg[TD_W-1:DATE_LSB])
                    && (prev_min != 7'h59)
                    && (new_min == bcd_min_inc(prev_min));

    // Capture each accepted frame as the reference for the next comparison.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            prev_reg <= '0;
        end else if (capture) begin
            prev_reg <= frame;
        end
    end

endmodule

// File: rtl/time_source_controller.sv
// Arbitrates writes into the clock register between DCF77 and manual setting,
// confirms DCF frames before loading, and selects the LCD display source.
module time_source_controller
    import time_source_controller_pkg::*;
#(
    parameter int CONFIRM_FRAMES = 2,
    parameter int TIMEOUT_TICKS  = 120
) (
    input  logic            clk,
    input  logic            nReset,
    input  logic            clk_en,
    input  logic            DCF_Enable_in,
    input  logic            DCF_set_in,
    input  logic [TD_W-1:0] DCF_timeAndDate_in,
    input  logic            SET_in,
    input  logic [TD_W-1:0] SetClock_timeAndDate_in,
    input  logic [TD_W-1:0] clock_timeAndDate_In,
    output logic [TD_W-1:0] LCD_timeAndDate_Out,
    output logic [TD_W-1:0] clock_timeAndDate_Out,
    output logic            clock_set_out,
    output logic            dcf_locked_out
);

    localparam int              TO_W    = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_TICKS - 1);

    logic [2:0]      state_reg, state_next;
    logic [2:0]      count_reg, count_next;
    logic            locked_reg, locked_next;
    logic [TO_W-1:0] timeout_reg;
    logic            load_dcf, load_man, capture;
    logic            plausible, waiting_dcf, timeout_hit, count_done;
    td_t             dcf_masked;

    time_source_controller_dcf_frame_checker u_checker (
        .clk       (clk),
        .nReset    (nReset),
        .frame     (DCF_timeAndDate_in),
        .capture   (capture),
        .plausible (plausible)
    );

    assign waiting_dcf = (state_reg == ST_CONFIRM) || (state_reg == ST_LOCKED);
    assign timeout_hit = waiting_dcf && clk_en && !DCF_set_in && (timeout_reg == TO_LAST);
    assign count_done  = ({1'b0, count_reg} + 4'd1) >= 4'(CONFIRM_FRAMES);

    // Loaded DCF time always starts at second zero of the decoded minute.
    always_comb begin
        dcf_masked        = DCF_timeAndDate_in;
        dcf_masked.sec_hi = '0;
        dcf_masked.sec_lo = '0;
    end

    // Next-state logic; manual setting pre-empts everything, including a pending frame.
    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        locked_next = locked_reg;
        load_dcf    = 1'b0;
        load_man    = 1'b0;
        capture     = 1'b0;
        if (SET_in) begin
            state_next  = ST_MANUAL;
            count_next  = 3'd0;
            locked_next = 1'b0;
        end else begin
            case (state_reg)
                ST_FREE: begin
                    if (DCF_set_in && DCF_Enable_in) begin
                        capture    = 1'b1;
                        count_next = 3'd1;
                        if (CONFIRM_FRAMES <= 1) begin
                            state_next = ST_DCF_LOAD;
                            load_dcf   = 1'b1;
                        end else begin
                            state_next = ST_CONFIRM;
                        end
                    end
                end
                ST_CONFIRM, ST_LOCKED: begin
                    if (!DCF_Enable_in || timeout_hit) begin
                        state_next  = ST_FREE;
                        count_next  = 3'd0;
                        locked_next = 1'b0;
                    end else if (DCF_set_in) begin
                        capture = 1'b1;
                        if (plausible) begin
                            count_next = (count_reg == 3'd7) ? count_reg : count_reg + 3'd1;
                            if ((state_reg == ST_LOCKED) || count_done) begin
                                state_next = ST_DCF_LOAD;
                                load_dcf   = 1'b1;
                            end
                        end else begin
                            state_next  = ST_CONFIRM;
                            count_next  = 3'd1;
                            locked_next = 1'b0;
                        end
                    end
                end
                ST_DCF_LOAD: begin
                    if (!DCF_Enable_in) begin
                        state_next  = ST_FREE;
                        count_next  = 3'd0;
                        locked_next = 1'b0;
                    end else begin
                        state_next  = ST_LOCKED;
                        locked_next = 1'b1;
                    end
                end
                ST_MANUAL: begin
                    state_next = ST_MAN_LOAD;
                    load_man   = 1'b1;
                end
                default: begin
                    state_next = ST_FREE;
                end
            endcase
        end
    end

    // FSM state, confirmation count and lock flag.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_reg  <= ST_FREE;
            count_reg  <= 3'd0;
            locked_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            locked_reg <= locked_next;
        end
    end

    // Seconds since the last DCF frame; only advances while waiting on DCF.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            timeout_reg <= '0;
        end else if (DCF_set_in || timeout_hit) begin
            timeout_reg <= '0;
        end else if (waiting_dcf && clk_en) begin
            timeout_reg <= timeout_reg + 1'b1;
        end else if (!waiting_dcf && (state_reg != ST_DCF_LOAD)) begin
            timeout_reg <= '0;
        end
    end

    // Registered outputs: load strobe/value and the LCD source mux.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            clock_set_out         <= 1'b0;
            clock_timeAndDate_Out <= '0;
            LCD_timeAndDate_Out   <= '0;
        end else begin
            clock_set_out <= load_dcf || load_man;
            if (load_dcf) begin
                clock_timeAndDate_Out <= dcf_masked;
            end else if (load_man) begin
                clock_timeAndDate_Out <= SetClock_timeAndDate_in;
            end
            LCD_timeAndDate_Out <= (state_reg == ST_MANUAL) ? SetClock_timeAndDate_in
                                                            : clock_timeAndDate_In;
        end
    end

    assign dcf_locked_out = locked_reg;

endmodule

// File: tb/tb_time_source_controller.sv
// Bench for time_source_controller: directed DCF/manual scenarios, an
// event-level reference model compared every cycle, plus literal spot checks.
module tb_time_source_controller;

    localparam int CF = 2;
    localparam int TO = 120;

    logic        clk = 1'b0;
    logic        nReset = 1'b0;
    logic        clk_en = 1'b0;
    logic        DCF_Enable_in = 1'b0;
    logic        DCF_set_in = 1'b0;
    logic [43:0] DCF_timeAndDate_in = '0;
    logic        SET_in = 1'b0;
    logic [43:0] SetClock_timeAndDate_in = '0;
    logic [43:0] clock_timeAndDate_In = '0;
    logic [43:0] LCD_timeAndDate_Out;
    logic [43:0] clock_timeAndDate_Out;
    logic        clock_set_out;
    logic        dcf_locked_out;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    time_source_controller #(.CONFIRM_FRAMES(CF), .TIMEOUT_TICKS(TO)) dut (
        .clk                     (clk),
        .nReset                  (nReset),
        .clk_en                  (clk_en),
        .DCF_Enable_in           (DCF_Enable_in),
        .DCF_set_in              (DCF_set_in),
        .DCF_timeAndDate_in      (DCF_timeAndDate_in),
        .SET_in                  (SET_in),
        .SetClock_timeAndDate_in (SetClock_timeAndDate_in),
        .clock_timeAndDate_In    (clock_timeAndDate_In),
        .LCD_timeAndDate_Out     (LCD_timeAndDate_Out),
        .clock_timeAndDate_Out   (clock_timeAndDate_Out),
        .clock_set_out           (clock_set_out),
        .dcf_locked_out          (dcf_locked_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [43:0] act, input logic [43:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    function automatic logic [43:0] mk(input int h, input int mi, input int s,
                                       input int d, input int mo, input int y);
        logic [43:0] f;
        f = '0;
        f[3:0]   = 4'(s % 10);  f[6:4]   = 3'(s / 10);
        f[10:7]  = 4'(mi % 10); f[13:11] = 3'(mi / 10);
        f[17:14] = 4'(h % 10);  f[19:18] = 2'(h / 10);
        f[23:20] = 4'(d % 10);  f[25:24] = 2'(d / 10);
        f[28:26] = 3'd3;
        f[32:29] = 4'(mo % 10); f[33]    = 1'(mo / 10);
        f[37:34] = 4'(y % 10);  f[41:38] = 4'(y / 10);
        f[43:42] = 2'd1;
        return f;
    endfunction

    function automatic logic [43:0] dt(input int h, input int mi, input int s);
        return mk(h, mi, s, 15, 6, 24);
    endfunction

    // Reference model: minutes as integers, a streak of agreeing frames and event flags.
    function automatic int minute_of(input logic [43:0] f);
        return int'(f[13:11]) * 10 + int'(f[10:7]);
    endfunction

    function automatic bit next_minute(input logic [43:0] prev, input logic [43:0] nw);
        return (nw[43:14] == prev[43:14]) && (minute_of(prev) < 59)
            && (minute_of(nw) == minute_of(prev) + 1);
    endfunction

    logic [43:0] exp_out = '0, exp_lcd = '0, m_prev = '0;
    logic        exp_strobe = 1'b0, exp_locked = 1'b0;
    bit          m_manual = 0, m_manload = 0, m_dcfload = 0;
    int          m_streak = 0, m_idle = 0;

    task automatic model_step();
        bit tracking, do_load;
        exp_lcd    = m_manual ? SetClock_timeAndDate_in : clock_timeAndDate_In;
        exp_strobe = 1'b0;
        do_load    = 0;
        if (DCF_set_in) m_idle = 0;
        tracking = (m_streak > 0) || exp_locked || m_dcfload;
        if (SET_in) begin
            m_manual = 1; m_manload = 0; m_dcfload = 0;
            m_streak = 0; exp_locked = 1'b0; m_idle = 0;
        end else if (m_manual) begin
            m_manual = 0; m_manload = 1;
            exp_strobe = 1'b1; exp_out = SetClock_timeAndDate_in;
        end else if (m_manload) begin
            m_manload = 0;
        end else if (tracking && !DCF_Enable_in) begin
            m_streak = 0; exp_locked = 1'b0; m_dcfload = 0; m_idle = 0;
        end else if (m_dcfload) begin
            m_dcfload = 0; exp_locked = 1'b1;
        end else if (DCF_set_in && DCF_Enable_in) begin
            if (m_streak == 0 && !exp_locked) m_streak = 1;
            else if (next_minute(m_prev, DCF_timeAndDate_in)) m_streak++;
            else begin m_streak = 1; exp_locked = 1'b0; end
            do_load = exp_locked || (m_streak >= CF);
            m_prev = DCF_timeAndDate_in;
            if (do_load) begin
                m_dcfload = 1; exp_strobe = 1'b1;
                exp_out = {DCF_timeAndDate_in[43:7], 7'd0};
            end
        end else if (tracking && clk_en) begin
            m_idle++;
            if (m_idle >= TO) begin m_streak = 0; exp_locked = 1'b0; m_idle = 0; end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge nReset);
        if (!nReset) begin
            exp_out = '0; exp_lcd = '0; exp_strobe = 1'b0; exp_locked = 1'b0;
            m_prev = '0; m_manual = 0; m_manload = 0; m_dcfload = 0;
            m_streak = 0; m_idle = 0;
        end else begin
            model_step();
        end
    end

    // Every-cycle comparison against the model, sampled on the falling edge.
    initial forever begin
        @(negedge clk);
        check("cyc_strobe", 44'(clock_set_out), 44'(exp_strobe));
        check("cyc_locked", 44'(dcf_locked_out), 44'(exp_locked));
        check("cyc_out", clock_timeAndDate_Out, exp_out);
        check("cyc_lcd", LCD_timeAndDate_Out, exp_lcd);
    end

    task automatic cyc();
        logic [63:0] r;
        @(posedge clk);
        #1;
        r = {$urandom, $urandom};
        clock_timeAndDate_In = r[43:0];
    endtask

    task automatic pulse(input logic [43:0] f);
        DCF_timeAndDate_in = f;
        DCF_set_in = 1'b1;
        cyc();
        DCF_set_in = 1'b0;
        $display("dcf frame %h set=%b en=%b -> strobe=%b out=%h locked=%b",
                 f, SET_in, DCF_Enable_in, clock_set_out, clock_timeAndDate_Out, dcf_locked_out);
    endtask

    task automatic gap();
        repeat (3) cyc();
    endtask

    logic [43:0] sv_val;

    initial begin
        sv_val = mk(23, 59, 57, 31, 6, 19);
        repeat (3) cyc();
        check("rst_strobe", 44'(clock_set_out), 44'd0);
        check("rst_locked", 44'(dcf_locked_out), 44'd0);
        check("rst_out", clock_timeAndDate_Out, 44'd0);
        check("rst_lcd", LCD_timeAndDate_Out, 44'd0);
        nReset = 1'b1;
        DCF_Enable_in = 1'b1;
        gap();

        // 1: confirm 12:00 -> 12:01, then minute resync at 12:02
        pulse(dt(12, 0, 3));
        check("t1_first_no_strobe", 44'(clock_set_out), 44'd0);
        gap();
        pulse(dt(12, 1, 3));
        check("t1_strobe", 44'(clock_set_out), 44'd1);
        check("t1_out", clock_timeAndDate_Out, dt(12, 1, 0));
        cyc();
        check("t1_strobe_drop", 44'(clock_set_out), 44'd0);
        check("t1_locked", 44'(dcf_locked_out), 44'd1);
        gap();
        pulse(dt(12, 2, 3));
        check("t1_resync_strobe", 44'(clock_set_out), 44'd1);
        check("t1_resync_out", clock_timeAndDate_Out, dt(12, 2, 0));
        gap();

        // 2: 12:00 then 12:05 rejected, 12:06 confirms
        pulse(dt(12, 0, 0));
        check("t2_unlock", 44'(dcf_locked_out), 44'd0);
        gap();
        pulse(dt(12, 5, 0));
        check("t2_gap_no_strobe", 44'(clock_set_out), 44'd0);
        gap();
        pulse(dt(12, 6, 0));
        check("t2_strobe", 44'(clock_set_out), 44'd1);
        check("t2_out", clock_timeAndDate_Out, dt(12, 6, 0));
        gap();

        // 3: timeout after 120 silent ticks
        for (int i = 1; i <= TO; i++) begin
            clk_en = 1'b1;
            cyc();
            clk_en = 1'b0;
            if (i == TO - 1) check("t3_locked_before", 44'(dcf_locked_out), 44'd1);
            if (i == TO) check("t3_unlocked", 44'(dcf_locked_out), 44'd0);
            cyc();
        end
        pulse(dt(12, 7, 0));
        check("t3_free_no_load", 44'(clock_set_out), 44'd0);
        gap();

        // 4: manual set pre-empts the confirming frame
        SetClock_timeAndDate_in = sv_val;
        SET_in = 1'b1;
        pulse(dt(12, 8, 0));
        check("t4_no_dcf_strobe", 44'(clock_set_out), 44'd0);
        cyc();
        check("t4_lcd", LCD_timeAndDate_Out, sv_val);
        gap();
        SET_in = 1'b0;
        cyc();
        $display("manual release -> strobe=%b out=%h", clock_set_out, clock_timeAndDate_Out);
        check("t4_strobe", 44'(clock_set_out), 44'd1);
        check("t4_out", clock_timeAndDate_Out, sv_val);
        cyc();
        check("t4_single_strobe", 44'(clock_set_out), 44'd0);
        gap();

        // 5: 12:59 -> 13:00 rejected; enable drop mid-confirm prevents a load
        pulse(dt(12, 59, 0));
        gap();
        pulse(dt(13, 0, 0));
        check("t5_hour_roll_reject", 44'(clock_set_out), 44'd0);
        gap();
        pulse(dt(13, 1, 0));
        check("t5_restart_strobe", 44'(clock_set_out), 44'd1);
        check("t5_restart_out", clock_timeAndDate_Out, dt(13, 1, 0));
        gap();
        pulse(dt(15, 0, 0));
        cyc();
        DCF_Enable_in = 1'b0;
        cyc();
        cyc();
        DCF_Enable_in = 1'b1;
        pulse(dt(15, 1, 0));
        check("t5_disable_no_load", 44'(clock_set_out), 44'd0);
        gap();
        pulse(dt(15, 2, 0));
        check("t5_reconfirm", 44'(clock_set_out), 44'd1);
        gap();

        // 6: reset asserted during the load cycle
        pulse(dt(15, 3, 0));
        check("t6_load_strobe", 44'(clock_set_out), 44'd1);
        nReset = 1'b0;
        #1;
        check("t6_strobe_cleared", 44'(clock_set_out), 44'd0);
        check("t6_out_cleared", clock_timeAndDate_Out, 44'd0);
        check("t6_locked_cleared", 44'(dcf_locked_out), 44'd0);
        repeat (2) @(posedge clk);
        #3;
        nReset = 1'b1;
        repeat (4) cyc();
        check("t6_no_late_load", 44'(clock_set_out), 44'd0);
        check("t6_out_held", clock_timeAndDate_Out, 44'd0);
        gap();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
